apb_port_demux: RTL and testbench

Single-master to N-slave APB3 address demultiplexer. It decodes a port index from the master's address and steers `psel`/`penable` to one slave. It returns that slave's `pready`/`prdata`/`pslverr` to the master and answers unmapped indices with an error. It sits between a configuration master and the register blocks of several peripherals. `pwrite`, `pwdata` and low address bits are broadcast to all slaves outside this block.

---
 rtl/apb_port_demux_pkg.sv | 26 ++
 rtl/apb_port_decode.sv | 22 ++
 rtl/apb_port_demux.sv | 103 ++++++++++
 tb/tb_apb_port_demux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_port_demux_pkg.sv
// Shared APB defaults and elaboration-time helpers for the port demultiplexer.
package apb_port_demux_pkg;

  localparam int APB_DATA_BITS = 32;
  localparam int APB_ADDR_BITS = 32;

  // Ceiling log2 for positive values; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Width of the port index field; never narrower than one bit.
  function automatic int sel_bits(input int num_ports);
    return (num_ports <= 1) ? 1 : clog2(num_ports);
  endfunction

endpackage

// File: rtl/apb_port_decode.sv
// Port index to one-hot select and mapped flag.
module apb_port_decode
  import apb_port_demux_pkg::*;
#(
  parameter int NumPorts = 2,
  parameter int SelBits  = 1
) (
  input  logic [SelBits-1:0]  i_sel,
  output logic [NumPorts-1:0] o_onehot,
  output logic                o_mapped
);

  // One-hot decode; an out-of-range index yields an all-zero vector.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NumPorts; i++) begin
      o_onehot[i] = (i_sel == SelBits'(i));
    end
    o_mapped = (32'(i_sel) < 32'(NumPorts));
  end

endmodule

// File: rtl/apb_port_demux.sv
// Single-master to N-slave APB3 demultiplexer. Steering is captured in the
// setup cycle and held through the access phase so that address changes
// during wait states cannot move the transfer to another slave.
module apb_port_demux
  import apb_port_demux_pkg::*;
#(
  parameter int NumPorts   = 2,
  parameter int AddrBits   = APB_ADDR_BITS,
  parameter int DataBits   = APB_DATA_BITS,
  parameter int PortSelLsb = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AddrBits-1:0]          slv_paddr,
  input  logic                         slv_psel,
  input  logic                         slv_penable,
  output logic                         slv_pready,
  output logic [DataBits-1:0]          slv_prdata,
  output logic                         slv_pslverr,
  output logic [NumPorts-1:0]          mst_psel,
  output logic [NumPorts-1:0]          mst_penable,
  input  logic [NumPorts-1:0]          mst_pready,
  input  logic [NumPorts*DataBits-1:0] mst_prdata,
  input  logic [NumPorts-1:0]          mst_pslverr
);

  localparam int SelBits = sel_bits(NumPorts);

  logic [SelBits-1:0]  r_sel_q;
  logic                r_map_q;
  logic                w_setup;
  logic [SelBits-1:0]  w_idx;
  logic [SelBits-1:0]  w_sel;
  logic [NumPorts-1:0] w_onehot;
  logic                w_sel_mapped;
  logic                w_map;
  logic                w_unused_addr;

  // Only the index field is decoded here; other address bits go to the slaves directly.
  assign w_unused_addr = ^slv_paddr;

  assign w_idx   = slv_paddr[PortSelLsb +: SelBits];
  assign w_setup = slv_psel & ~slv_penable;
  assign w_sel   = w_setup ? w_idx : r_sel_q;

  apb_port_decode #(
    .NumPorts (NumPorts),
    .SelBits  (SelBits)
  ) u_decode (
    .i_sel    (w_sel),
    .o_onehot (w_onehot),
    .o_mapped (w_sel_mapped)
  );

  // In setup the decoder sees the live index, so its mapped flag is the one to capture.
  assign w_map = w_setup ? w_sel_mapped : r_map_q;

  // Capture steering at the end of each setup cycle; hold it through the access phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_q <= '0;
      r_map_q <= 1'b0;
    end else if (w_setup) begin
      r_sel_q <= w_idx;
      r_map_q <= w_sel_mapped;
    end else begin
      r_sel_q <= r_sel_q;
      r_map_q <= r_map_q;
    end
  end

  // Combinational request steering and response return; everything is forced low in reset.
  always_comb begin
    mst_psel    = '0;
    mst_penable = '0;
    slv_pready  = 1'b0;
    slv_prdata  = '0;
    slv_pslverr = 1'b0;
    if (rst && slv_psel) begin
      if (w_map) begin
        mst_psel    = w_onehot;
        mst_penable = slv_penable ? w_onehot : '0;
        slv_pready  = |(w_onehot & mst_pready);
        slv_pslverr = |(w_onehot & mst_pslverr);
        for (int i = 0; i < NumPorts; i++) begin
          slv_prdata = slv_prdata
                     | (mst_prdata[i*DataBits +: DataBits] & {DataBits{w_onehot[i]}});
        end
      end else begin
        // Unmapped index: no slave is selected, the access phase completes with an error.
        slv_pready  = slv_penable;
        slv_pslverr = slv_penable;
      end
    end else begin
      mst_psel    = '0;
      mst_penable = '0;
      slv_pready  = 1'b0;
      slv_prdata  = '0;
      slv_pslverr = 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_port_demux.sv
// Directed bench for apb_port_demux: a cycle table on a 2-port instance plus
// hand sequences for reset mid-access and the unmapped-index boundary on a
// 3-port instance.
module tb_apb_port_demux;

  localparam logic [31:0] RD0 = 32'h1111_1111;
  localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RD2 = 32'hCAFE_0002;

  logic        clk;
  logic        rst;

  // 2-port instance
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [1:0]  m_psel;
  logic [1:0]  m_penable;
  logic [1:0]  m_pready;
  logic [63:0] m_prdata;
  logic [1:0]  m_pslverr;

  // 3-port instance
  logic [31:0] d3_paddr;
  logic        d3_psel;
  logic        d3_penable;
  logic        d3_pready;
  logic [31:0] d3_prdata;
  logic        d3_pslverr;
  logic [2:0]  d3_m_psel;
  logic [2:0]  d3_m_penable;
  logic [2:0]  d3_m_pready;
  logic [95:0] d3_m_prdata;
  logic [2:0]  d3_m_pslverr;

  int checks;
  int failures;

  apb_port_demux #(.NumPorts(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .slv_paddr   (paddr),
    .slv_psel    (psel),
    .slv_penable (penable),
    .slv_pready  (pready),
    .slv_prdata  (prdata),
    .slv_pslverr (pslverr),
    .mst_psel    (m_psel),
    .mst_penable (m_penable),
    .mst_pready  (m_pready),
    .mst_prdata  (m_prdata),
    .mst_pslverr (m_pslverr)
  );

  apb_port_demux #(.NumPorts(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .slv_paddr   (d3_paddr),
    .slv_psel    (d3_psel),
    .slv_penable (d3_penable),
    .slv_pready  (d3_pready),
    .slv_prdata  (d3_prdata),
    .slv_pslverr (d3_pslverr),
    .mst_psel    (d3_m_psel),
    .mst_penable (d3_m_penable),
    .mst_pready  (d3_m_pready),
    .mst_prdata  (d3_m_prdata),
    .mst_pslverr (d3_m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        psel;
    logic        pen;
    logic [31:0] addr;
    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [1:0]  e_psel;
    logic [1:0]  e_pen;
    logic        e_rdy;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] e_psel, input logic [1:0] e_pen,
                      input logic e_rdy, input logic [31:0] e_data, input logic e_err);
    chk({tag, " mst_psel"},    32'(m_psel),    32'(e_psel));
    chk({tag, " mst_penable"}, 32'(m_penable), 32'(e_pen));
    chk({tag, " pready"},      32'(pready),    32'(e_rdy));
    chk({tag, " prdata"},      prdata,         e_data);
    chk({tag, " pslverr"},     32'(pslverr),   32'(e_err));
  endtask

  task automatic chk3(input string tag, input logic [2:0] e_psel, input logic [2:0] e_pen,
                      input logic e_rdy, input logic [31:0] e_data, input logic e_err);
    chk({tag, " mst_psel"},    32'(d3_m_psel),    32'(e_psel));
    chk({tag, " mst_penable"}, 32'(d3_m_penable), 32'(e_pen));
    chk({tag, " pready"},      32'(d3_pready),    32'(e_rdy));
    chk({tag, " prdata"},      d3_prdata,         e_data);
    chk({tag, " pslverr"},     32'(d3_pslverr),   32'(e_err));
  endtask

  task automatic drive2(input logic s, input logic e, input logic [31:0] a,
                        input logic [1:0] r, input logic [1:0] er);
    psel      = s;
    penable   = e;
    paddr     = a;
    m_pready  = r;
    m_pslverr = er;
  endtask

  task automatic drive3(input logic s, input logic e, input logic [31:0] a, input logic [2:0] r);
    d3_psel     = s;
    d3_penable  = e;
    d3_paddr    = a;
    d3_m_pready = r;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          psel  pen   addr          rdy    err    e_psel e_pen  e_rdy e_data  e_err
    // idle
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // write 0x0004, port 0 ready immediately: 2-cycle transfer
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0004, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, RD0,   1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0004, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, RD0,   1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // read 0x1008, port 1 ready after 3 wait states
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_1008, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, RD1,   1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_1008, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, RD1,   1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_1008, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, RD1,   1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_1008, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, RD1,   1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_1008, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1, RD1,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // with two ports the index field is only bit 12, so 0x2000 aliases port 0
    vecs[10] = '{1'b1, 1'b0, 32'h0000_2000, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, RD0,   1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_2000, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, RD0,   1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // port 0 error only in the completing cycle; idle afterwards masks the slave's error
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, RD0,   1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, RD0,   1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0000, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1, RD0,   1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_0000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // address moves to port 1 during port-0 wait states: steering must not follow
    vecs[17] = '{1'b1, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, RD0,   1'b0};
    vecs[18] = '{1'b1, 1'b1, 32'h0000_1000, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0, RD0,   1'b0};
    vecs[19] = '{1'b1, 1'b1, 32'h0000_1000, 2'b11, 2'b00, 2'b01, 2'b01, 1'b1, RD0,   1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
    // access without setup reuses the last capture (port 0, mapped)
    vecs[21] = '{1'b1, 1'b1, 32'h0000_1000, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, RD0,   1'b0};
    // penable without psel is idle
    vecs[22] = '{1'b0, 1'b1, 32'h0000_1000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};

    m_prdata     = {RD1, RD0};
    d3_m_prdata  = {RD2, RD1, RD0};
    d3_m_pslverr = 3'b000;
    drive3(1'b0, 1'b0, 32'h0, 3'b000);

    // Reset held with an active-looking bus: every output must be low.
    rst = 1'b0;
    drive2(1'b1, 1'b1, 32'h0000_1000, 2'b11, 2'b11);
    #2;
    chk2("reset_held", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk2("reset_held_clk", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);

    // First access straight after reset without setup: map_q is 0, so unmapped error.
    @(negedge clk);
    rst = 1'b1;
    drive2(1'b1, 1'b1, 32'h0000_0000, 2'b01, 2'b00);
    #1;
    chk2("post_reset_access", 2'b00, 2'b00, 1'b1, 32'h0, 1'b1);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive2(vecs[k].psel, vecs[k].pen, vecs[k].addr, vecs[k].rdy, vecs[k].err);
      #1;
      chk2($sformatf("vec%0d", k), vecs[k].e_psel, vecs[k].e_pen,
           vecs[k].e_rdy, vecs[k].e_data, vecs[k].e_err);
    end

    // Reset asserted mid-access to port 1, then released while the access phase continues.
    @(negedge clk);
    drive2(1'b1, 1'b0, 32'h0000_1000, 2'b00, 2'b00);
    #1;
    chk2("rst_seq_setup", 2'b10, 2'b00, 1'b0, RD1, 1'b0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk2("rst_seq_access", 2'b10, 2'b10, 1'b0, RD1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk2("rst_seq_async", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk2("rst_seq_held", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk2("rst_seq_release", 2'b00, 2'b00, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    drive2(1'b1, 1'b0, 32'h0000_1000, 2'b10, 2'b00);
    #1;
    chk2("rst_seq_resetup", 2'b10, 2'b00, 1'b1, RD1, 1'b0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk2("rst_seq_reaccess", 2'b10, 2'b10, 1'b1, RD1, 1'b0);
    @(negedge clk);
    drive2(1'b0, 1'b0, 32'h0, 2'b00, 2'b00);

    // Three ports: index 2 is the last mapped port, index 3 is the first unmapped one.
    @(negedge clk);
    drive3(1'b1, 1'b0, 32'h0000_2000, 3'b100);
    #1;
    chk3("p3_idx2_setup", 3'b100, 3'b000, 1'b1, RD2, 1'b0);
    @(negedge clk);
    d3_penable = 1'b1;
    #1;
    chk3("p3_idx2_access", 3'b100, 3'b100, 1'b1, RD2, 1'b0);
    @(negedge clk);
    drive3(1'b0, 1'b0, 32'h0, 3'b000);
    @(negedge clk);
    drive3(1'b1, 1'b0, 32'h0000_3000, 3'b111);
    #1;
    chk3("p3_idx3_setup", 3'b000, 3'b000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    d3_penable = 1'b1;
    #1;
    chk3("p3_idx3_access", 3'b000, 3'b000, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    drive3(1'b0, 1'b0, 32'h0, 3'b111);
    #1;
    chk3("p3_idle", 3'b000, 3'b000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive3(1'b1, 1'b0, 32'h0000_1004, 3'b010);
    #1;
    chk3("p3_idx1_setup", 3'b010, 3'b000, 1'b1, RD1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
